z_run_logger: RTL and testbench

Downstream consumer of the 2-bit run detector's `z`/`InIdle` outputs. It timestamps every `z` high run, measures its length in cycles, and queues one record per completed run in a small first-word-fall-through (FWFT) FIFO. A valid/ready port drains the FIFO. Overflow, drop count and detector protocol violations are exposed for the bench and for software.

---
 rtl/z_log_pkg.sv | 14 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/z_run_logger.sv | 91 +++++++++
 tb/tb_z_run_logger.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/z_log_pkg.sv
// Shared types and defaults for the z run logger: record layout, widths and
// the run-length saturation value.
package z_log_pkg;
  localparam int TS_W_DEF  = 8;
  localparam int LEN_W_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [LEN_W_DEF-1:0] len;
  } z_rec_t;

  localparam logic [LEN_W_DEF-1:0] LEN_MAX = '1;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// succeeds when a pop happens in the same cycle, otherwise it is reported as drop.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop_req,
  output logic [DATA_W-1:0]        head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              pop, push_ok;

  always_comb begin
    valid   = (cnt_q != '0);
    pop     = pop_req && valid;
    push_ok = push && ((cnt_q != FULL_CNT) || pop);
    drop    = push && !push_ok;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    head  = valid ? mem_q[rd_q] : '0;
  end

  assign count = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/z_run_logger.sv
// Timestamps each z-high run, measures its length and queues {start ts, length}
// records in a FWFT FIFO drained over a valid/ready port.
module z_run_logger
  import z_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     z,
  input  logic                     in_idle,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TS_W-1:0]          rec_ts,
  output logic [LEN_W-1:0]         rec_len,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     protocol_err
);
  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_cnt(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_W-1:0]  ts_q, ts_d, run_ts_q, run_ts_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic             z_q, z_d, overflow_q, overflow_d, prot_err_q, prot_err_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             push, drop;
  logic [TS_W+LEN_W-1:0] head;

  always_comb begin
    ts_d       = ts_q + 1'b1;
    z_d        = z;
    run_ts_d   = run_ts_q;
    run_len_d  = run_len_q;
    push       = z_q && !z;
    if (z && !z_q) begin
      run_ts_d  = ts_q;
      run_len_d = LEN_W'(1);
    end else if (z && z_q) begin
      run_len_d = sat_inc_len(run_len_q);
    end
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop ? sat_inc_cnt(drop_cnt_q) : drop_cnt_q;
    prot_err_d = prot_err_q | (z & in_idle);
  end

  sync_fifo #(.DATA_W(TS_W + LEN_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({run_ts_q, run_len_q}),
    .pop_req   (rec_ready),
    .head      (head),
    .valid     (rec_valid),
    .count     (fifo_count),
    .drop      (drop)
  );

  assign {rec_ts, rec_len} = head;
  assign overflow          = overflow_q;
  assign drop_cnt          = drop_cnt_q;
  assign protocol_err      = prot_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      z_q        <= 1'b0;
      run_ts_q   <= '0;
      run_len_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      prot_err_q <= 1'b0;
    end else begin
      ts_q       <= ts_d;
      z_q        <= z_d;
      run_ts_q   <= run_ts_d;
      run_len_q  <= run_len_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      prot_err_q <= prot_err_d;
    end
  end
endmodule

// File: tb/tb_z_run_logger.sv
// Scoreboard bench for z_run_logger: directed runs push expected records,
// a negedge monitor pops and compares every accepted record.
module tb_z_run_logger;
  import z_log_pkg::*;

  logic       clk = 1'b0;
  logic       rst, z, in_idle, rec_ready;
  logic       rec_valid, overflow, protocol_err;
  logic [7:0] rec_ts, rec_len, drop_cnt;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  z_rec_t exp_q[$];

  z_run_logger dut (
    .clk(clk), .rst(rst), .z(z), .in_idle(in_idle),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_ts(rec_ts), .rec_len(rec_len), .fifo_count(fifo_count),
    .overflow(overflow), .drop_cnt(drop_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a record is consumed at the edge following a negedge where valid&ready.
  always @(negedge clk) begin
    if (rst === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got ts=%0d len=%0d expected none", rec_ts, rec_len);
      end else begin
        z_rec_t e;
        e = exp_q.pop_front();
        if (rec_ts !== e.ts || rec_len !== e.len) begin
          errors++;
          $display("FAIL record: got ts=%0d len=%0d expected ts=%0d len=%0d",
                   rec_ts, rec_len, e.ts, e.len);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rec_valid"}, rec_valid, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_protocol_err"}, protocol_err, 0);
    chk({tag, "_rec_ts"}, rec_ts, 0);
    chk({tag, "_rec_len"}, rec_len, 0);
  endtask

  // After return the next rising edge samples ts_q = 0.
  task automatic do_reset();
    rst = 1'b1; z = 1'b0; in_idle = 1'b0; rec_ready = 1'b0;
    #1;
    chk_zero("rst_held");
    step(2);
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk_zero("rst_released");
  endtask

  task automatic single_run(input logic [7:0] ts, input bit expect_stored);
    z = 1'b1; step(1);
    z = 1'b0; step(1);
    if (expect_stored) exp_q.push_back('{ts: ts, len: 8'd1});
  endtask

  task automatic drain(input int n);
    rec_ready = 1'b1; step(n);
    rec_ready = 1'b0;
    chk("drain_count", fifo_count, 0);
    chk("drain_valid", rec_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; z = 1'b0; in_idle = 1'b0; rec_ready = 1'b0;
    step(1);

    // Basic run: z high at edges ts=5..8
    do_reset();
    step(5);
    z = 1'b1; step(4);
    z = 1'b0;
    chk("t1_valid_before_fall", rec_valid, 0);
    step(1);
    exp_q.push_back('{ts: 8'd5, len: 8'd4});
    chk("t1_valid_after_fall", rec_valid, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_protocol_err", protocol_err, 0);
    chk("t1_head_ts", rec_ts, 5);
    chk("t1_head_len", rec_len, 4);
    drain(1);
    chk("t1_empty_ts", rec_ts, 0);
    chk("t1_empty_len", rec_len, 0);

    // Overflow: five single-cycle runs, no draining
    do_reset();
    for (int i = 0; i < 4; i++) single_run(8'(2 * i), 1'b1);
    chk("t2_count_full", fifo_count, 4);
    chk("t2_no_overflow_yet", overflow, 0);
    step(3);
    chk("t2_head_stable_ts", rec_ts, 0);
    chk("t2_head_stable_len", rec_len, 1);
    single_run(8'd14, 1'b0);
    chk("t2_count", fifo_count, 4);
    chk("t2_overflow", overflow, 1);
    chk("t2_drop_cnt", drop_cnt, 1);
    drain(4);

    // Push into full FIFO with a simultaneous pop
    do_reset();
    for (int i = 0; i < 4; i++) single_run(8'(2 * i), 1'b1);
    z = 1'b1; step(1);
    z = 1'b0; rec_ready = 1'b1; step(1);
    rec_ready = 1'b0;
    exp_q.push_back('{ts: 8'd8, len: 8'd1});
    chk("t3_count", fifo_count, 4);
    chk("t3_drop_cnt", drop_cnt, 0);
    chk("t3_overflow", overflow, 0);
    drain(4);

    // Long run across timestamp wrap, length saturates
    do_reset();
    step(254);
    z = 1'b1; step(300);
    z = 1'b0; step(1);
    exp_q.push_back('{ts: 8'd254, len: LEN_MAX});
    chk("t4_count", fifo_count, 1);
    chk("t4_overflow", overflow, 0);
    chk("t4_head_len", rec_len, 255);
    drain(1);

    // Reset in the middle of a run with two records queued
    do_reset();
    single_run(8'd0, 1'b1);
    single_run(8'd2, 1'b1);
    z = 1'b1; step(2);
    chk("t5_count_before", fifo_count, 2);
    rst = 1'b1; z = 1'b0;
    #1;
    chk("t5_async_valid", rec_valid, 0);
    chk("t5_async_count", fifo_count, 0);
    do_reset();
    step(5);
    chk("t5_no_record_valid", rec_valid, 0);
    chk("t5_no_record_count", fifo_count, 0);

    // Protocol error: z and in_idle high together
    do_reset();
    step(3);
    z = 1'b1; in_idle = 1'b1; step(1);
    in_idle = 1'b0;
    chk("t6_protocol_err_set", protocol_err, 1);
    step(1);
    z = 1'b0; step(1);
    exp_q.push_back('{ts: 8'd3, len: 8'd2});
    chk("t6_record_present", fifo_count, 1);
    step(10);
    chk("t6_protocol_err_sticky", protocol_err, 1);
    drain(1);
    chk("t6_protocol_err_after_drain", protocol_err, 1);
    do_reset();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
